mm_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single matrix-memory port (i/j/index addressing, 20-bit read data, 40-bit write data) between the matrix-multiply engine (requester 0) and the host loader/unloader (requester 1). It sits between both requesters and the memory model. It grants the port with round-robin fairness, a hold limit against starvation, and a lock input for uninterruptible sequences.

---
 rtl/mm_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mm_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_port_arbiter.sv
// Round-robin arbiter sharing one matrix-memory port between the multiply engine (0) and host (1).
// Optional access counters are built only when MM_ARB_STATS_EN is defined.
module mm_port_arbiter #(
  parameter int AW       = 20,
  parameter int RW       = 20,
  parameter int WW       = 40,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] i0,
  input  logic [AW-1:0] j0,
  input  logic [AW-1:0] i1,
  input  logic [AW-1:0] j1,
  input  logic          index0,
  input  logic          index1,
  input  logic          read0,
  input  logic          write0,
  input  logic          read1,
  input  logic          write1,
  input  logic [WW-1:0] wdata0,
  input  logic [WW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [RW-1:0] rdata_o,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_i,
  output logic [AW-1:0] mem_j,
  output logic          mem_index,
  output logic          mem_read,
  output logic          mem_write,
  output logic [WW-1:0] mem_wdata,
  input  logic [RW-1:0] mem_rdata,
  output logic [31:0]   cnt0,
  output logic [31:0]   cnt1
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state;
  state_t        state_next;
  logic          rr_ptr;
  logic          rr_ptr_next;
  logic [HW-1:0] hold_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        hold_cnt <= '0;
        rr_ptr   <= rr_ptr_next;
      end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // A locked grantee is never preempted; an unlocked one yields once its hold budget is spent.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_next = rr_ptr ? G1 : G0;
        else if (req0)    state_next = G0;
        else if (req1)    state_next = G1;
      end
      G0: begin
        if (!req0)                                        state_next = req1 ? G1 : IDLE;
        else if (hold_cnt == HOLD_LAST && req1 && !lock0) state_next = G1;
      end
      G1: begin
        if (!req1)                                        state_next = req0 ? G0 : IDLE;
        else if (hold_cnt == HOLD_LAST && req0 && !lock1) state_next = G0;
      end
      default: state_next = IDLE;
    endcase

    rr_ptr_next = rr_ptr;
    case (state_next)
      G0:      rr_ptr_next = 1'b1;
      G1:      rr_ptr_next = 1'b0;
      default: rr_ptr_next = (state == G0);
    endcase
  end

  always_comb begin
    gnt0      = (state == G0);
    gnt1      = (state == G1);
    mem_i     = '0;
    mem_j     = '0;
    mem_index = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    if (gnt0 && req0) begin
      mem_i     = i0;
      mem_j     = j0;
      mem_index = index0;
      mem_read  = read0;
      mem_write = write0;
      mem_wdata = wdata0;
    end else if (gnt1 && req1) begin
      mem_i     = i1;
      mem_j     = j1;
      mem_index = index1;
      mem_read  = read1;
      mem_write = write1;
      mem_wdata = wdata1;
    end
    rvalid0 = gnt0 & read0 & req0;
    rvalid1 = gnt1 & read1 & req1;
  end

  assign rdata_o = mem_rdata;

`ifdef MM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0 && req0 && (read0 || write0)) cnt0 <= cnt0 + 32'd1;
      if (gnt1 && req1 && (read1 || write1)) cnt1 <= cnt1 + 32'd1;
    end
  end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Scoreboard bench for mm_port_arbiter: expectations are queued as stimulus is driven
// and checked mid-cycle on the falling edge.
module tb_mm_port_arbiter;

  localparam int AW = 20;
  localparam int RW = 20;
  localparam int WW = 40;

  logic          clk;
  logic          reset;
  logic          req0, req1, lock0, lock1;
  logic [AW-1:0] i0, j0, i1, j1;
  logic          index0, index1;
  logic          read0, write0, read1, write1;
  logic [WW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [RW-1:0] rdata_o;
  logic          rvalid0, rvalid1;
  logic [AW-1:0] mem_i, mem_j;
  logic          mem_index, mem_read, mem_write;
  logic [WW-1:0] mem_wdata;
  logic [RW-1:0] mem_rdata;
  logic [31:0]   cnt0, cnt1;

  typedef struct {
    string       tag;
    logic [63:0] value;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  mm_port_arbiter #(.AW(AW), .RW(RW), .WW(WW), .MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .i0(i0), .j0(j0), .i1(i1), .j1(j1),
    .index0(index0), .index1(index1),
    .read0(read0), .write0(write0), .read1(read1), .write1(write1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata_o(rdata_o),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_i(mem_i), .mem_j(mem_j), .mem_index(mem_index),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] observe(input string tag);
    case (tag)
      "gnt0":      return 64'(gnt0);
      "gnt1":      return 64'(gnt1);
      "rvalid0":   return 64'(rvalid0);
      "rvalid1":   return 64'(rvalid1);
      "rdata":     return 64'(rdata_o);
      "mem_i":     return 64'(mem_i);
      "mem_j":     return 64'(mem_j);
      "mem_index": return 64'(mem_index);
      "mem_read":  return 64'(mem_read);
      "mem_write": return 64'(mem_write);
      "mem_wdata": return 64'(mem_wdata);
      "cnt0":      return 64'(cnt0);
      "cnt1":      return 64'(cnt1);
      default:     return '1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic push_expect(input string tag, input logic [63:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  // Sample mid-cycle, retire every queued expectation, then move just past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.tag), e.value);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic l0, input logic rd0, input logic wr0,
                               input logic r1, input logic l1, input logic rd1, input logic wr1);
    req0 = r0; lock0 = l0; read0 = rd0; write0 = wr0;
    req1 = r1; lock1 = l1; read1 = rd1; write1 = wr1;
  endtask

  task automatic push_grants(input logic g0, input logic g1);
    push_expect("gnt0", 64'(g0));
    push_expect("gnt1", 64'(g1));
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    push_grants(0, 0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    i0 = '0; j0 = '0; i1 = '0; j1 = '0;
    index0 = 1'b0; index1 = 1'b0;
    wdata0 = '0; wdata1 = '0;
    mem_rdata = '0;
    @(posedge clk);
    #1;

    // Reset state
    push_grants(0, 0);
    push_expect("mem_read", 0);
    push_expect("mem_write", 0);
    push_expect("mem_i", 0);
    push_expect("mem_j", 0);
    push_expect("mem_index", 0);
    push_expect("mem_wdata", 0);
    push_expect("rvalid0", 0);
    push_expect("rvalid1", 0);
    push_expect("cnt0", 0);
    push_expect("cnt1", 0);
    tick();
    reset = 1'b1;

    // Single requester read: one cycle of grant latency, then the port carries requester 0
    i0 = 20'd1; j0 = 20'd2; index0 = 1'b0; mem_rdata = 20'h00005;
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    push_grants(0, 0);
    push_expect("rvalid0", 0);
    push_expect("mem_read", 0);
    tick();
    for (int c = 0; c < 2; c++) begin
      push_grants(1, 0);
      push_expect("mem_i", 1);
      push_expect("mem_j", 2);
      push_expect("mem_index", 0);
      push_expect("mem_read", 1);
      push_expect("mem_write", 0);
      push_expect("rvalid0", 1);
      push_expect("rvalid1", 0);
      push_expect("rdata", 20'h00005);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    push_grants(1, 0);
    push_expect("mem_read", 0);
    push_expect("mem_i", 0);
    push_expect("rvalid0", 0);
    tick();
    push_grants(0, 0);
    tick();

    // Simultaneous requests from reset: 0 first, hand-over without an idle gap
    do_reset();
    i0 = 20'd3; i1 = 20'd7; mem_rdata = 20'hABCDE;
    applyStimulus(1, 0, 1, 0, 1, 0, 1, 0);
    push_grants(0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      push_grants(1, 0);
      push_expect("mem_i", 3);
      push_expect("rvalid0", 1);
      push_expect("rvalid1", 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    push_grants(1, 0);
    push_expect("mem_i", 0);
    push_expect("mem_read", 0);
    tick();
    push_grants(0, 1);
    push_expect("mem_i", 7);
    push_expect("rvalid1", 1);
    push_expect("rdata", 20'hABCDE);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    push_grants(0, 1);
    push_expect("rvalid1", 0);
    tick();
    push_grants(0, 0);
    tick();

    // Preference has returned to requester 0, then fairness blocks and a lock on requester 1
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    push_grants(0, 0);
    tick();
    for (int k = 0; k < 90; k++) begin
      logic g0;
      if (k < 48)       g0 = ((k / 16) % 2) == 0;
      else if (k <= 88) g0 = 1'b0;
      else              g0 = 1'b1;
      lock1 = (k >= 48) && (k < 88);
      push_grants(g0, !g0);
      tick();
    end

    // Asynchronous reset in the middle of a requester-1 write
    do_reset();
    i1 = 20'd5; wdata1 = 40'hFF_FFFF_FFFE;
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    push_grants(0, 0);
    tick();
    push_grants(0, 1);
    push_expect("mem_write", 1);
    push_expect("mem_wdata", 40'hFF_FFFF_FFFE);
    push_expect("mem_i", 5);
    tick();
    reset = 1'b0;
    push_grants(0, 0);
    push_expect("mem_write", 0);
    push_expect("mem_wdata", 0);
    tick();
    reset = 1'b1;
    push_grants(0, 0);
    tick();
    push_grants(0, 1);
    push_expect("mem_write", 1);
    tick();

    // Access counters: 10 reads by requester 0, then 7 writes by requester 1
    do_reset();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    push_grants(0, 0);
    tick();
    for (int c = 0; c < 10; c++) begin
      push_grants(1, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    push_grants(1, 0);
`ifdef MM_ARB_STATS_EN
    push_expect("cnt0", 10);
`else
    push_expect("cnt0", 0);
`endif
    tick();
    for (int c = 0; c < 7; c++) begin
      push_grants(0, 1);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    push_grants(0, 1);
    tick();
`ifdef MM_ARB_STATS_EN
    push_expect("cnt0", 10);
    push_expect("cnt1", 7);
`else
    push_expect("cnt0", 0);
    push_expect("cnt1", 0);
`endif
    push_grants(0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
